// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit.
package mips_lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Big-endian lane offsets within a word
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_LB)  || (op == OP_LH)  ||
           (op == OP_LW)  || (op == OP_LBU) ||
           (op == OP_LHU) || (op == OP_SB)  ||
           (op == OP_SH)  || (op == OP_SW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Byte-lane extract/extend for loads and
// lane merge for sub-word stores.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld,
  output logic [31:0] o_st
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_off)
      LANE_B0: w_byte = i_word[31:24];
      LANE_B1: w_byte = i_word[23:16];
      LANE_B2: w_byte = i_word[15:8];
      LANE_B3: w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_word[15:0]
                      : i_word[31:16];
  end

  always_comb begin
    o_ld = 32'h0;
    case (i_op)
      OP_LB:  o_ld = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_ld = {24'h0, w_byte};
      OP_LH:  o_ld = {{16{w_half[15]}}, w_half};
      OP_LHU: o_ld = {16'h0, w_half};
      OP_LW:  o_ld = i_word;
      default: o_ld = 32'h0;
    endcase
  end

  always_comb begin
    o_st = i_word;
    case (i_op)
      OP_SB: begin
        unique case (i_off)
          LANE_B0: o_st[31:24] = i_wdata[7:0];
          LANE_B1: o_st[23:16] = i_wdata[7:0];
          LANE_B2: o_st[15:8]  = i_wdata[7:0];
          LANE_B3: o_st[7:0]   = i_wdata[7:0];
          default: o_st = i_word;
        endcase
      end
      OP_SH: begin
        if (i_off[1]) o_st[15:0]  = i_wdata[15:0];
        else          o_st[31:16] = i_wdata[15:0];
      end
      OP_SW:   o_st = i_wdata;
      default: o_st = i_word;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit on the MIPS data-memory bus.
// MIPS_LSU_ALIGN_CHECK_EN traps misaligned accesses.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       write_data,
  output logic              sig_mem_read,
  output logic              sig_mem_write,
  input  logic [31:0]       read_data
);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_maddr;
  logic [31:0]       r_wdout;
  logic              r_rd;
  logic              r_wr;
  logic              r_resp_valid;
  logic [31:0]       r_rdata;
  logic              r_mis;

  logic              w_legal;
  logic              w_mis;
  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_ld;
  logic [31:0]       w_st;

  assign w_legal = is_legal(req_op);
  assign w_waddr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  assign w_mis = w_legal &&
    ((is_half(req_op) && req_addr[0]) ||
     (is_word(req_op) && (req_addr[1:0] != 2'b00)));
  assign w_off = req_addr[1:0];
`else
  // Misaligned addresses are silently rounded down
  assign w_mis = 1'b0;
  assign w_off = is_word(req_op) ? 2'b00 :
                 is_half(req_op) ? {req_addr[1], 1'b0} :
                                   req_addr[1:0];
`endif

  mips_lsu_lane u_lane (
    .i_op    (r_op),
    .i_off   (r_off),
    .i_word  (read_data),
    .i_wdata (r_wdata),
    .o_ld    (w_ld),
    .o_st    (w_st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= 4'h0;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_maddr      <= '0;
      r_wdout      <= 32'h0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_mis        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_off   <= w_off;
            r_wdata <= req_wdata;
            if (!w_legal || w_mis) begin
              r_state      <= ST_DONE;
              r_resp_valid <= 1'b1;
              r_rdata      <= 32'h0;
              r_mis        <= w_mis;
            end else if (req_op == OP_SW) begin
              r_state <= ST_WR;
              r_wr    <= 1'b1;
              r_maddr <= w_waddr;
              r_wdout <= req_wdata;
            end else begin
              r_state <= ST_RD;
              r_rd    <= 1'b1;
              r_maddr <= w_waddr;
            end
          end
        end
        ST_RD: begin
          r_rd <= 1'b0;
          // Stores reaching RD are SB/SH: merge and write back
          if (r_op[3]) begin
            r_state <= ST_WR;
            r_wr    <= 1'b1;
            r_wdout <= w_st;
          end else begin
            r_state      <= ST_DONE;
            r_maddr      <= '0;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_ld;
            r_mis        <= 1'b0;
          end
        end
        ST_WR: begin
          r_wr         <= 1'b0;
          r_maddr      <= '0;
          r_wdout      <= 32'h0;
          r_state      <= ST_DONE;
          r_resp_valid <= 1'b1;
          r_rdata      <= 32'h0;
          r_mis        <= 1'b0;
        end
        ST_DONE: begin
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = (r_state == ST_IDLE);
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_rdata;
  assign resp_misaligned = r_mis;
  assign mem_address     = r_maddr;
  assign write_data      = r_wdout;
  assign sig_mem_read    = r_rd;
  assign sig_mem_write   = r_wr;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed scoreboard bench for mips_lsu
// against a small behavioural data memory.
module tb_mips_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        sig_mem_read;
  logic        sig_mem_write;
  logic [31:0] read_data;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int mon_bad = 0;
  logic [31:0] last_rd_addr = 0;
  logic [31:0] last_wr_addr = 0;
  logic [31:0] last_wr_data = 0;

  logic [32:0] exp_q [$];

  mips_lsu #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_address     (mem_address),
    .write_data      (write_data),
    .sig_mem_read    (sig_mem_read),
    .sig_mem_write   (sig_mem_write),
    .read_data       (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign read_data = mem[mem_address[7:2]];

  always @(posedge clk)
    if (sig_mem_write) mem[mem_address[7:2]] <= write_data;

  always @(negedge clk) begin
    if (sig_mem_read) begin
      rd_cnt       = rd_cnt + 1;
      last_rd_addr = mem_address;
    end
    if (sig_mem_write) begin
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = mem_address;
      last_wr_data = write_data;
    end
    if (sig_mem_read && sig_mem_write) mon_bad = mon_bad + 1;
    if (mem_address[1:0] != 2'b00) mon_bad = mon_bad + 1;
    if (!sig_mem_read && !sig_mem_write &&
        (mem_address != 0 || write_data != 0))
      mon_bad = mon_bad + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag,
                       input logic [3:0] op,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] exp_rd,
                       input logic exp_mis,
                       input int lat,
                       input int nrd,
                       input int nwr);
    int r0, w0, b0, cyc;
    logic [32:0] e;
    @(negedge clk);
    r0 = rd_cnt; w0 = wr_cnt; b0 = mon_bad;
    req_valid = 1'b1; req_op = op;
    req_addr = addr; req_wdata = wd;
    chk({tag, " ready"}, req_ready, 1);
    @(posedge clk);
    exp_q.push_back({exp_rd, exp_mis});
    #1 req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    e = exp_q.pop_front();
    chk({tag, " rdata"}, resp_rdata, e[32:1]);
    chk({tag, " misaligned"}, resp_misaligned, e[0]);
    @(negedge clk); #1;
    chk({tag, " reads"}, rd_cnt - r0, nrd);
    chk({tag, " writes"}, wr_cnt - w0, nwr);
    chk({tag, " bus"}, mon_bad - b0, 0);
  endtask

  initial begin
    logic [32:0] e;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0;
    req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst mis", resp_misaligned, 0);
    chk("rst addr", mem_address, 0);
    chk("rst wdata", write_data, 0);
    chk("rst rd", sig_mem_read, 0);
    chk("rst wr", sig_mem_write, 0);
    @(negedge clk) rst_n = 1'b1;

    issue("sw10", 4'b1010, 32'h10, 32'h11223344,
          32'h0, 1'b0, 2, 0, 1);
    chk("sw10 addr", last_wr_addr, 32'h10);
    chk("sw10 data", last_wr_data, 32'h11223344);
    issue("lw10", 4'b0010, 32'h10, 32'h0,
          32'h11223344, 1'b0, 2, 1, 0);
    chk("lw10 addr", last_rd_addr, 32'h10);
    repeat (2) @(posedge clk);
    #1 chk("rdata hold", resp_rdata, 32'h11223344);

    issue("sw10b", 4'b1010, 32'h10, 32'h8899AABB,
          32'h0, 1'b0, 2, 0, 1);
    issue("lb13", 4'b0000, 32'h13, 32'h0,
          32'hFFFFFFBB, 1'b0, 2, 1, 0);
    issue("lb10", 4'b0000, 32'h10, 32'h0,
          32'hFFFFFF88, 1'b0, 2, 1, 0);
    issue("lbu10", 4'b0100, 32'h10, 32'h0,
          32'h00000088, 1'b0, 2, 1, 0);
    issue("lbu11", 4'b0100, 32'h11, 32'h0,
          32'h00000099, 1'b0, 2, 1, 0);
    issue("lhu12", 4'b0101, 32'h12, 32'h0,
          32'h0000AABB, 1'b0, 2, 1, 0);
    issue("lh12", 4'b0001, 32'h12, 32'h0,
          32'hFFFFAABB, 1'b0, 2, 1, 0);
    issue("lh10", 4'b0001, 32'h10, 32'h0,
          32'hFFFF8899, 1'b0, 2, 1, 0);

    issue("sw20", 4'b1010, 32'h20, 32'h01020304,
          32'h0, 1'b0, 2, 0, 1);
    issue("sb21", 4'b1000, 32'h21, 32'hFFFFFF5A,
          32'h0, 1'b0, 3, 1, 1);
    chk("sb21 addr", last_wr_addr, 32'h20);
    chk("sb21 data", last_wr_data, 32'h015A0304);
    chk("sb21 mem", mem[8], 32'h015A0304);
    issue("sh22", 4'b1001, 32'h22, 32'hABCD1234,
          32'h0, 1'b0, 3, 1, 1);
    chk("sh22 data", last_wr_data, 32'h015A1234);

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    issue("lh11", 4'b0001, 32'h11, 32'h0,
          32'h0, 1'b1, 1, 0, 0);
`else
    issue("lh11", 4'b0001, 32'h11, 32'h0,
          32'hFFFF8899, 1'b0, 2, 1, 0);
    chk("lh11 addr", last_rd_addr, 32'h10);
`endif

    issue("illegal", 4'b0011, 32'h10, 32'h0,
          32'h0, 1'b0, 1, 0, 0);

    // SH interrupted by reset during its write cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1001;
    req_addr = 32'h20; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rstmid wr", sig_mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid wr drop", sig_mem_write, 0);
    chk("rstmid rd drop", sig_mem_read, 0);
    chk("rstmid addr", mem_address, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("rstmid no resp", resp_valid, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rstmid ready", req_ready, 1);
    chk("rstmid mem", mem[8], 32'h015A1234);

    // Back-to-back SW then LW with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1010;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    exp_q.push_back({32'h0, 1'b0});
    #1 req_op = 4'b0010; req_wdata = 32'h0;
    @(posedge clk);
    #1 chk("b2b sw resp", resp_valid, 1);
    e = exp_q.pop_front();
    chk("b2b sw rdata", resp_rdata, e[32:1]);
    chk("b2b sw ready", req_ready, 0);
    @(posedge clk);
    #1 chk("b2b idle ready", req_ready, 1);
    chk("b2b idle resp", resp_valid, 0);
    @(posedge clk);
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    #1 chk("b2b accepted", req_ready, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 chk("b2b lw resp", resp_valid, 1);
    e = exp_q.pop_front();
    chk("b2b lw rdata", resp_rdata, e[32:1]);
    chk("b2b lw mis", resp_misaligned, e[0]);
    @(posedge clk);
    #1 chk("b2b pulse", resp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit that acts as the initiator on the data-memory bus of the MIPS datapath. It accepts one load or store from the MEM stage through a valid/ready handshake and turns it into single-cycle word-wide read/write strobes on the byte-addressed, big-endian data memory. Sub-word stores (SB/SH) are done as read-modify-write, and load data is extracted and sign- or zero-extended. It returns one response per request.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle; request accepted when valid && ready
- req_op  in  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; other codes illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; the byte or halfword is right-justified
- resp_valid  out  1  one-cycle pulse, one per accepted request
- resp_rdata  out  32  extended load result; 0 for stores
- resp_misaligned  out  1  qualified by resp_valid
- mem_address  out  ADDR_W  word-aligned byte address, low 2 bits always 00
- write_data  out  32  full word to memory
- sig_mem_read  out  1  read strobe
- sig_mem_write  out  1  write strobe
- read_data  in  32  combinational memory read data, valid in the same cycle as sig_mem_read

## Operation
- States: IDLE, RD, WR, DONE.
- req_ready is 1 only in IDLE. Request fields are latched on acceptance.
- LW, LH, LHU, LB, LBU: IDLE → RD → DONE.
- SW: IDLE → WR → DONE.
- SB, SH: IDLE → RD → WR → DONE.
- Misaligned request (halfword with addr[0]=1, or word with addr[1:0]≠0): IDLE → DONE with resp_misaligned=1. No memory strobe is issued.
- Illegal op: IDLE → DONE with resp_misaligned=0 and rdata 0. No memory access.
- RD:
  - sig_mem_read=1; read_data is captured into a word register at the end of the cycle.
- WR:
  - sig_mem_write=1.
  - write_data = req_wdata for SW. For SB/SH it is the captured word with the target lane replaced.
- Byte lanes are big-endian: offset 0 → bits[31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0]. Halfword offset 0 → [31:16], 2 → [15:0].
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- DONE: resp_valid=1 for exactly one cycle, then → IDLE.
- All memory-side outputs come from flops, and the memory write is level-sensitive. Therefore:
  - sig_mem_write is high for exactly one cycle.
  - mem_address and write_data are stable for that whole cycle.
  - The strobes are 0 and mem_address/write_data are 0 in every state except RD/WR.
- sig_mem_read and sig_mem_write are never both 1.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_misaligned 0, mem_address 0, write_data 0, sig_mem_read 0, sig_mem_write 0.
- Latency is measured from the accept edge (cycle 0) to the resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - misaligned or illegal: 1 cycle
- Throughput: a new request can be accepted in the cycle after DONE, because req_ready returns high in IDLE.
- resp_rdata and resp_misaligned hold their values until the next DONE.
- Reset asserted mid-operation:
  - All strobes drop to 0 immediately (asynchronously) and the FSM goes to IDLE.
  - No response is produced; a partially done RMW leaves memory unwritten.
- req_valid dropping while the LSU is busy has no effect.

## Configuration
- MIPS_LSU_ALIGN_CHECK_EN
  - Defined: misaligned requests are trapped as described above.
  - Undefined: alignment is not checked. The address is forced to halfword alignment for LH/LHU/SH (addr[0] treated as 0) and to word alignment for LW/SW (addr[1:0] treated as 0), the access proceeds normally, and resp_misaligned is tied to 0.

## Structure
- Package mips_lsu_pkg holds:
  - the op encodings as localparams
  - the state enum
  - a byte-lane offset helper constant set
- One sub-module, mips_lsu_lane: purely combinational; does load extraction/extension and store lane merge from (op, addr[1:0], word, wdata).

## Test plan
- LW from 0x10, memory word 0x11223344 → sig_mem_read for 1 cycle at mem_address 0x10; resp_rdata 0x11223344 two cycles after accept.
- LB at 0x13 and at 0x10 on word 0x8899AABB → 0xFFFFFFBB and 0xFFFFFF88. LBU at 0x10 → 0x00000088. LHU at 0x12 → 0x0000AABB.
- SB 0x5A to 0x21, word at 0x20 = 0x01020304 → RD then WR; write_data 0x015A0304; sig_mem_write high for exactly 1 cycle; resp_valid at cycle 3.
- LH at 0x11 with the macro defined → resp_misaligned=1 at cycle 1 and no strobes. Without the macro → read at 0x10, upper halfword returned.
- Reset pulled low during the WR cycle of an SH → sig_mem_write falls without waiting for a clock edge, no resp_valid, req_ready=1 after release.
- Back-to-back SW 0xDEADBEEF to 0x40 then LW from 0x40, with req_valid held high → the second request is accepted the cycle after the first DONE and returns 0xDEADBEEF.
